seed_editor: RTL and testbench

Interactive seed-pattern editor that sits directly upstream of the 8×8 Game of Life engine. It turns push-button and switch inputs into the 64-bit initial board the engine loads while its `reset` is high. It keeps a cursor that is moved and toggled by debounced-clean key edges, supports clear and preset loading, and drives a preview image with a blinking cursor so the user can see where they are editing.

---
 rtl/seed_editor.sv | 111 +++++++++++
 tb/tb_seed_editor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seed_editor.sv
// Seed-pattern editor for the 8x8 Life engine: conditions key inputs into
// single-cycle events, edits a 64-bit board under a cursor and drives a blinking preview.
module seed_editor #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            edit_en,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_toggle,
  input  logic            key_clear,
  input  logic            key_load,
  input  logic [1:0]      preset_sel,
  output logic [7:0][7:0] board,
  output logic [7:0][7:0] display,
  output logic [2:0]      cursor_x,
  output logic [2:0]      cursor_y
);
  localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  // key vector order doubles as priority order: bit 0 wins
  localparam int K_CLR = 0, K_LOAD = 1, K_TGL = 2, K_UP = 3, K_DN = 4, K_LT = 5, K_RT = 6;

  logic [6:0]      keys;
  logic [6:0]      sync1_q, sync2_q, prev_q, ev;
  logic [7:0][7:0] board_q, board_d, disp_q, disp_d, preset;
  logic [2:0]      cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]   cnt_q;
  logic            phase_q;

  assign keys = {key_right, key_left, key_down, key_up, key_toggle, key_load, key_clear};
  assign ev   = sync2_q & ~prev_q;

  always_comb begin
    preset = '0;
    case (preset_sel)
      2'd0: begin
        preset[1][2] = 1'b1; preset[2][1] = 1'b1;
        preset[0][0] = 1'b1; preset[1][0] = 1'b1; preset[2][0] = 1'b1;
      end
      2'd1: begin
        preset[3][3] = 1'b1; preset[3][4] = 1'b1; preset[3][5] = 1'b1;
      end
      2'd2: begin
        preset[3][3] = 1'b1; preset[4][3] = 1'b1;
        preset[3][4] = 1'b1; preset[4][4] = 1'b1;
      end
      default: begin
        for (int x = 0; x < 8; x++)
          for (int y = 0; y < 8; y++)
            preset[x][y] = ((x + y) % 2) == 0;
      end
    endcase
  end

  always_comb begin
    board_d = board_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (edit_en) begin
      if (ev[K_CLR])       board_d = '0;
      else if (ev[K_LOAD]) board_d = preset;
      else if (ev[K_TGL])  board_d[cx_q][cy_q] = ~board_q[cx_q][cy_q];
      else if (ev[K_UP])   begin if (cy_q != 3'd7) cy_d = cy_q + 3'd1; end
      else if (ev[K_DN])   begin if (cy_q != 3'd0) cy_d = cy_q - 3'd1; end
      else if (ev[K_LT])   begin if (cx_q != 3'd0) cx_d = cx_q - 3'd1; end
      else if (ev[K_RT])   begin if (cx_q != 3'd7) cx_d = cx_q + 3'd1; end
    end
  end

  always_comb begin
    disp_d = board_q;
    if (edit_en && phase_q) disp_d[cx_q][cy_q] = ~board_q[cx_q][cy_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      board_q <= '0;
      disp_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      board_q <= board_d;
      disp_q  <= disp_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      if (cnt_q == CW'(BLINK_CYCLES - 1)) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  assign board    = board_q;
  assign display  = disp_q;
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;
endmodule

// File: tb/tb_seed_editor.sv
// Bench for seed_editor: directed steps plus random key traffic, every cycle
// compared against a cycle-count based reference of the editor's behaviour.
module tb_seed_editor;
  localparam int BC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            edit_en;
  logic [6:0]      keys;   // {right,left,down,up,toggle,load,clear}
  logic [1:0]      preset_sel;
  logic [7:0][7:0] board, display;
  logic [2:0]      cursor_x, cursor_y;

  int checks = 0;
  int errors = 0;

  seed_editor #(.BLINK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .edit_en(edit_en),
    .key_up(keys[3]), .key_down(keys[4]), .key_left(keys[5]), .key_right(keys[6]),
    .key_toggle(keys[2]), .key_clear(keys[0]), .key_load(keys[1]),
    .preset_sel(preset_sel), .board(board), .display(display),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  // reference state
  logic [7:0][7:0] mb, md;
  int              cx, cy, cnt;
  logic [6:0]      h1, h2, h3;   // key levels seen at the last three edges
  bit              rst_prev;

  function automatic logic [7:0][7:0] preset_of(input logic [1:0] sel);
    logic [7:0][7:0] p;
    int gx[5] = '{1, 2, 0, 1, 2};
    int gy[5] = '{2, 1, 0, 0, 0};
    p = '0;
    case (sel)
      2'd0: for (int i = 0; i < 5; i++) p[gx[i]][gy[i]] = 1'b1;
      2'd1: for (int i = 3; i <= 5; i++) p[3][i] = 1'b1;
      2'd2: for (int x = 3; x <= 4; x++) for (int y = 3; y <= 4; y++) p[x][y] = 1'b1;
      default: for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) p[x][y] = ((x + y) % 2) == 0;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the reference, then compare all outputs.
  task automatic step(input int n = 1);
    logic [6:0] ev;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (reset) begin
        mb = '0; md = '0; cx = 0; cy = 0; cnt = 0;
        h3 = h2; h2 = h1; h1 = '0; rst_prev = 1'b1;
      end else begin
        // a key level seen at edge t-2 but not t-3 acts at edge t
        ev = rst_prev ? 7'd0 : (h2 & ~h3);
        md = mb;
        if (edit_en && ((cnt / BC) % 2 == 1)) md[cx][cy] = ~md[cx][cy];
        if (edit_en && ev != 0) begin
          if (ev[0])      mb = '0;
          else if (ev[1]) mb = preset_of(preset_sel);
          else if (ev[2]) mb[cx][cy] = ~mb[cx][cy];
          else if (ev[3]) cy = (cy < 7) ? cy + 1 : 7;
          else if (ev[4]) cy = (cy > 0) ? cy - 1 : 0;
          else if (ev[5]) cx = (cx > 0) ? cx - 1 : 0;
          else            cx = (cx < 7) ? cx + 1 : 7;
        end
        cnt++;
        h3 = h2; h2 = h1; h1 = keys; rst_prev = 1'b0;
      end
      #1;
      chk("board", board, mb);
      chk("display", display, md);
      chk("cursor_x", 64'(cursor_x), 64'(cx));
      chk("cursor_y", 64'(cursor_y), 64'(cy));
    end
  endtask

  task automatic press(input logic [6:0] m, input int times);
    for (int i = 0; i < times; i++) begin
      keys = m; step(3);
      keys = '0; step(3);
    end
  endtask

  initial begin
    int idx;
    h1 = '0; h2 = '0; h3 = '0; rst_prev = 1'b1;
    reset = 1'b1; edit_en = 1'b1; keys = '0; preset_sel = 2'd0;
    step(3);
    chk("reset_board", board, 64'd0);
    chk("reset_display", display, 64'd0);
    reset = 1'b0;
    step(16);                             // blink of cursor (0,0) on empty board

    keys = 7'b1000000; step(1);           // right rises before edge N
    step(1); chk("right_n1", 64'(cursor_x), 64'd0);
    step(1); chk("right_n2", 64'(cursor_x), 64'd1);
    step(17); chk("right_held", 64'(cursor_x), 64'd1);
    keys = '0; step(3);

    press(7'b1000000, 9);
    press(7'b0001000, 9);
    chk("sat_x", 64'(cursor_x), 64'd7);
    chk("sat_y", 64'(cursor_y), 64'd7);
    press(7'b0100000, 1);
    chk("left_once", 64'(cursor_x), 64'd6);

    press(7'b0100000, 4);
    press(7'b0010000, 4);
    press(7'b0000100, 1);
    chk("toggle_on", board, 64'd1 << (2 * 8 + 3));
    press(7'b0000100, 1);
    chk("toggle_off", board, 64'd0);

    preset_sel = 2'd1;
    press(7'b0000010, 1);
    chk("blinker", board, (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 29));
    press(7'b0000101, 1);
    chk("clear_wins", board, 64'd0);

    edit_en = 1'b0;
    preset_sel = 2'd3;
    press(7'b0000010, 1);
    press(7'b1000000, 2);
    step(8);
    edit_en = 1'b1;
    step(8);

    press(7'b0000010, 1);
    keys = 7'b0001000; step(2);
    reset = 1'b1; step(2);
    chk("rst_board", board, 64'd0);
    reset = 1'b0; step(6);
    chk("rst_move", 64'(cursor_y), 64'd1);
    keys = '0; step(4);

    for (int i = 0; i < 600; i++) begin
      idx = $urandom_range(0, 24);
      if (idx < 2)       keys = 7'b1 << idx;
      else if (idx < 14) keys = 7'b1 << (idx % 5 + 2);
      else if (idx == 14) keys = 7'($urandom);
      else               keys = '0;
      edit_en    = ($urandom_range(0, 7) != 0);
      preset_sel = 2'($urandom);
      reset      = ($urandom_range(0, 80) == 0);
      step($urandom_range(1, 3));
    end
    reset = 1'b0; keys = '0; step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
